upsampling_job_ctrl: RTL and testbench

Sequences one up-sampling job at a time from the configuration register file to the up-sampling datapath/DMA engine. Polls the start/end registers, launches a job with the programmed source/destination addresses, and waits for engine completion. Then writes back through the PL-side register write port: it clears start and sets end, which raises the PS interrupt. Sits between the config register file (PL side) and the up-sampling engine.

---
 rtl/upsampling_job_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_upsampling_job_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/upsampling_job_ctrl.sv
// upsampling_job_ctrl
// Runs one up-sampling job at a time. It polls the start and end registers,
// hands the programmed source and destination addresses to the engine, and
// waits for the engine to finish. It then clears UPSTR and sets UPENDR through
// the PL write port. Writing UPENDR raises the PS interrupt.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   crf_ac_UPSTR/UPENDR         start / end registers (bit0 start, bit0 done, bit1 error)
//   crf_ac_UPSRCAR/UPDSTAR      job source / destination address
//   crf_ac_wbusy                register file is busy with a PS write; a PL write stalls
//   ac_crf_wrt/waddr/wdata      PL register write (waddr 0 = UPSTR, 1 = UPENDR)
//   job_valid/job_ready         job handshake to the engine
//   job_src_addr/job_dst_addr   addresses latched at launch
//   eng_done                    single-cycle engine completion pulse
//   ac_busy                     controller is not idle
//   job_cnt                     number of completed jobs; wraps
//
// Optional macro AC_TIMEOUT_EN: adds a watchdog. If the engine has not
// finished TIMEOUT_CYCLES-1 cycles after launch, the controller ends the job
// with done|error and does not count it.
module upsampling_job_ctrl #(
  parameter int unsigned CRF_DATA_WIDTH = 32,
  parameter int unsigned CRF_ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSTR,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPENDR,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSRCAR,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPDSTAR,
  input  logic                      crf_ac_wbusy,
  output logic                      ac_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
  output logic                      job_valid,
  input  logic                      job_ready,
  output logic [CRF_DATA_WIDTH-1:0] job_src_addr,
  output logic [CRF_DATA_WIDTH-1:0] job_dst_addr,
  input  logic                      eng_done,
  output logic                      ac_busy,
  output logic [CNT_WIDTH-1:0]      job_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_WR_CLR = 3'd3,
    S_WR_END = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      wrt_q, wrt_d;
  logic [CRF_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [CRF_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      valid_q, valid_d;
  logic [CRF_DATA_WIDTH-1:0] src_q, src_d;
  logic [CRF_DATA_WIDTH-1:0] dst_q, dst_d;
  logic                      busy_q, busy_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      timeout_c;
  logic                      unused_bits;

`ifdef AC_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;

  // Watchdog: cleared on launch, counts in LAUNCH/RUN, saturates at the limit.
  // Saturating means a handshake in the limit cycle still times out in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (state_q == S_IDLE && state_d == S_LAUNCH) begin
      wd_q <= '0;
    end else if ((state_q == S_LAUNCH || state_q == S_RUN) && wd_q != WD_MAX) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign timeout_c = (state_q == S_LAUNCH || state_q == S_RUN) && (wd_q == WD_MAX);

  // Error flag for the job in progress; it selects done|error in the end write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign unused_bits = ^{crf_ac_UPSTR[CRF_DATA_WIDTH-1:1], crf_ac_UPENDR[CRF_DATA_WIDTH-1:1]};
`else
  assign timeout_c   = 1'b0;
  assign err_q       = 1'b0;
  assign unused_bits = ^{crf_ac_UPSTR[CRF_DATA_WIDTH-1:1], crf_ac_UPENDR[CRF_DATA_WIDTH-1:1],
                         err_d, 32'(TIMEOUT_CYCLES)};
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wrt_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wrt_q   <= wrt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and next outputs.
  always_comb begin
    state_d = state_q;
    wrt_d   = wrt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        // UPENDR[0] still set means the previous interrupt is not acknowledged.
        if (crf_ac_UPSTR[0] && !crf_ac_UPENDR[0]) begin
          state_d = S_LAUNCH;
          valid_d = 1'b1;
          src_d   = crf_ac_UPSRCAR;
          dst_d   = crf_ac_UPDSTAR;
          err_d   = 1'b0;
        end
      end
      S_LAUNCH: begin
        if (valid_q && job_ready) begin
          valid_d = 1'b0;
          state_d = S_RUN;
        end else if (timeout_c) begin
          valid_d = 1'b0;
          state_d = S_WR_CLR;
          wrt_d   = 1'b1;
          waddr_d = '0;
          wdata_d = '0;
          err_d   = 1'b1;
        end
      end
      S_RUN: begin
        // A completion in the timeout cycle still counts as a normal finish.
        if (eng_done || timeout_c) begin
          state_d = S_WR_CLR;
          wrt_d   = 1'b1;
          waddr_d = '0;
          wdata_d = '0;
          err_d   = !eng_done;
        end
      end
      S_WR_CLR: begin
        if (!crf_ac_wbusy) begin
          state_d = S_WR_END;
          waddr_d = CRF_ADDR_WIDTH'(1);
          wdata_d = err_q ? CRF_DATA_WIDTH'(3) : CRF_DATA_WIDTH'(1);
        end
      end
      S_WR_END: begin
        if (!crf_ac_wbusy) begin
          state_d = S_IDLE;
          wrt_d   = 1'b0;
          if (!err_q) cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign ac_crf_wrt   = wrt_q;
  assign ac_crf_waddr = waddr_q;
  assign ac_crf_wdata = wdata_q;
  assign job_valid    = valid_q;
  assign job_src_addr = src_q;
  assign job_dst_addr = dst_q;
  assign ac_busy      = busy_q;
  assign job_cnt      = cnt_q;

endmodule

// File: tb/tb_upsampling_job_ctrl.sv
// Testbench for upsampling_job_ctrl. The bench models the register file, the
// PS and the engine. A job-level scoreboard holds the launch addresses, the
// expected write pairs and the job count.
module tb_upsampling_job_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] crf_ac_UPSTR, crf_ac_UPENDR, crf_ac_UPSRCAR, crf_ac_UPDSTAR;
  logic        crf_ac_wbusy;
  logic        ac_crf_wrt;
  logic [31:0] ac_crf_waddr, ac_crf_wdata;
  logic        job_valid, job_ready;
  logic [31:0] job_src_addr, job_dst_addr;
  logic        eng_done, ac_busy;
  logic [15:0] job_cnt;

  upsampling_job_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .crf_ac_UPSTR(crf_ac_UPSTR), .crf_ac_UPENDR(crf_ac_UPENDR),
    .crf_ac_UPSRCAR(crf_ac_UPSRCAR), .crf_ac_UPDSTAR(crf_ac_UPDSTAR),
    .crf_ac_wbusy(crf_ac_wbusy),
    .ac_crf_wrt(ac_crf_wrt), .ac_crf_waddr(ac_crf_waddr), .ac_crf_wdata(ac_crf_wdata),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_src_addr(job_src_addr), .job_dst_addr(job_dst_addr),
    .eng_done(eng_done), .ac_busy(ac_busy), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_n    = 0;
  int hs_cyc;
  logic [31:0] hs_src, hs_dst;
  logic [31:0] wq_addr[$], wq_data[$];
  int          wq_cyc[$];
  logic [15:0] exp_cnt = 16'd0;

  typedef struct {
    logic [31:0] src, dst;
    int rd, dd, wb1, wb2;
    int exp_hs, exp_clr, exp_end;
  } row_t;
  row_t rows[4];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one clock. Log handshakes and completed PL writes as they looked
  // just before the edge, and apply each completed write to the register model.
  task automatic tick();
    logic hs, pend;
    logic [31:0] pa, pd, ps, pq;
    hs = job_valid && job_ready;
    pend = ac_crf_wrt && !crf_ac_wbusy;
    pa = ac_crf_waddr; pd = ac_crf_wdata; ps = job_src_addr; pq = job_dst_addr;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (hs) begin hs_n++; hs_cyc = cyc; hs_src = ps; hs_dst = pq; end
    if (pend) begin
      wq_addr.push_back(pa); wq_data.push_back(pd); wq_cyc.push_back(cyc);
      if (pa == 32'd0) crf_ac_UPSTR = pd;
      else if (pa == 32'd1) crf_ac_UPENDR = pd;
    end
    check("wrt_only_in_write_states", {63'd0, ac_crf_wrt && (job_valid || !ac_busy)}, 64'd0);
  endtask

  task automatic run_job(input row_t r, input bit ack);
    int t0, hs0, w0, k;
    t0 = cyc; hs0 = hs_n; w0 = wq_addr.size();
    crf_ac_UPSRCAR = r.src; crf_ac_UPDSTAR = r.dst; crf_ac_UPSTR = 32'd1; job_ready = 1'b0;
    tick();
    check("valid_after_1cyc", {63'd0, job_valid}, 64'd1);
    check("src_latched", {32'd0, job_src_addr}, {32'd0, r.src});
    check("dst_latched", {32'd0, job_dst_addr}, {32'd0, r.dst});
    crf_ac_UPSRCAR = ~r.src; crf_ac_UPDSTAR = ~r.dst;
    repeat (r.rd) begin
      tick();
      check("bp_hold", {job_valid, job_src_addr, job_dst_addr}, {1'b1, r.src, r.dst});
    end
    job_ready = 1'b1;
    k = 0;
    while (hs_n == hs0 && k < 50) begin tick(); k++; end
    job_ready = 1'b0;
    repeat (r.dd) tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    crf_ac_wbusy = 1'b1;
    repeat (r.wb1) begin
      tick();
      check("wbusy_hold_clr", {ac_crf_wrt, ac_crf_waddr, ac_crf_wdata}, {1'b1, 32'd0, 32'd0});
    end
    crf_ac_wbusy = 1'b0;
    k = 0;
    while (wq_addr.size() < w0 + 1 && k < 50) begin tick(); k++; end
    crf_ac_wbusy = 1'b1;
    repeat (r.wb2) tick();
    crf_ac_wbusy = 1'b0;
    k = 0;
    while (wq_addr.size() < w0 + 2 && k < 50) begin tick(); k++; end
    exp_cnt++;
    check("one_handshake", 64'(hs_n - hs0), 64'd1);
    check("hs_latency", 64'(hs_cyc - t0), 64'(r.exp_hs));
    check("write_count", 64'(wq_addr.size() - w0), 64'd2);
    if (wq_addr.size() >= w0 + 2) begin
      check("clr_write", {wq_addr[w0], wq_data[w0]}, {32'd0, 32'd0});
      check("clr_cycle", 64'(wq_cyc[w0] - t0), 64'(r.exp_clr));
      check("end_write", {wq_addr[w0+1], wq_data[w0+1]}, {32'd1, 32'd1});
      check("end_cycle", 64'(wq_cyc[w0+1] - t0), 64'(r.exp_end));
    end
    check("job_cnt", {48'd0, job_cnt}, {48'd0, exp_cnt});
    check("idle_after", {62'd0, ac_busy, ac_crf_wrt}, 64'd0);
    if (ack) begin crf_ac_UPENDR = 32'd0; tick(); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int k, w0, hs0, t0;
    bit seen;
    logic [31:0] s, d;

    rows[0] = '{32'h1000_0000, 32'h2000_0000,  0, 50, 0, 0,  2, 54, 55};
    rows[1] = '{32'h1234_5678, 32'h8765_4321, 10,  5, 0, 0, 12, 19, 20};
    rows[2] = '{32'hAAAA_0000, 32'h5555_0000,  0,  3, 5, 0,  2, 12, 13};
    rows[3] = '{32'hDEAD_BEEF, 32'hCAFE_F00D,  2,  0, 1, 3,  4,  7, 11};

    rst_n = 1'b0;
    crf_ac_UPSTR = 0; crf_ac_UPENDR = 0; crf_ac_UPSRCAR = 0; crf_ac_UPDSTAR = 0;
    crf_ac_wbusy = 0; job_ready = 0; eng_done = 0;
    #3;
    check("rst_wr", {ac_crf_wrt, ac_crf_waddr, ac_crf_wdata}, 65'd0);
    check("rst_job", {job_valid, job_src_addr, job_dst_addr}, 65'd0);
    check("rst_busy_cnt", {47'd0, ac_busy, job_cnt}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Stray completion pulses while idle.
    eng_done = 1'b1; repeat (3) tick(); eng_done = 1'b0; tick();
    check("stray_idle_nowrite", 64'(wq_addr.size()), 64'd0);
    check("stray_idle_state", {62'd0, ac_busy, job_valid}, 64'd0);

    for (int i = 0; i < 4; i++) run_job(rows[i], i != 3);

    // The interrupt is still pending and the PS has already rewritten start.
    crf_ac_UPSTR = 32'd1; crf_ac_UPSRCAR = 32'h0BAD_0001; crf_ac_UPDSTAR = 32'h0BAD_0002;
    seen = 1'b0;
    repeat (10) begin tick(); if (job_valid) seen = 1'b1; end
    check("no_relaunch_unacked", {63'd0, seen}, 64'd0);
    crf_ac_UPENDR = 32'd0;
    tick();
    check("launch_after_ack", {job_valid, job_src_addr}, {1'b1, 32'h0BAD_0001});
    // A completion pulse in LAUNCH is ignored.
    w0 = wq_addr.size();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    check("stray_launch_hold", {63'd0, job_valid}, 64'd1);
    job_ready = 1'b1; tick(); job_ready = 1'b0;
    crf_ac_UPSRCAR = 32'hFFFF_FFFF; crf_ac_UPSTR = 32'd0;
    repeat (3) tick();
    check("run_state", {job_valid, ac_busy, job_src_addr}, {2'b01, 32'h0BAD_0001});
    check("stray_launch_nowrite", 64'(wq_addr.size() - w0), 64'd0);
    // Reset in RUN: outputs clear at once and no write-back is issued.
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr", {ac_crf_wrt, ac_crf_waddr, ac_crf_wdata}, 65'd0);
    check("midrst_job", {job_valid, job_src_addr, job_dst_addr}, 65'd0);
    check("midrst_busy_cnt", {47'd0, ac_busy, job_cnt}, 64'd0);
    exp_cnt = 16'd0;
    @(negedge clk); rst_n = 1'b1;
    eng_done = 1'b1; tick(); eng_done = 1'b0; tick();
    check("midrst_nowrite", 64'(wq_addr.size() - w0), 64'd0);
    check("midrst_idle", {62'd0, ac_busy, job_valid}, 64'd0);

`ifdef AC_TIMEOUT_EN
    // Watchdog: the engine never finishes.
    t0 = cyc; w0 = wq_addr.size();
    crf_ac_UPSRCAR = 32'h3000_0000; crf_ac_UPDSTAR = 32'h4000_0000; crf_ac_UPSTR = 32'd1;
    job_ready = 1'b1;
    k = 0;
    while (wq_addr.size() < w0 + 2 && k < 200) begin
      tick(); k++;
      if (job_valid == 1'b0) job_ready = 1'b0;
    end
    check("to_write_count", 64'(wq_addr.size() - w0), 64'd2);
    if (wq_addr.size() >= w0 + 2) begin
      check("to_clr", {wq_addr[w0], wq_data[w0]}, {32'd0, 32'd0});
      check("to_clr_cycle", 64'(wq_cyc[w0] - t0), 64'd66);
      check("to_end", {wq_addr[w0+1], wq_data[w0+1]}, {32'd1, 32'd3});
      check("to_end_cycle", 64'(wq_cyc[w0+1] - t0), 64'd67);
    end
    check("to_cnt_unchanged", {48'd0, job_cnt}, {48'd0, exp_cnt});
    crf_ac_UPENDR = 32'd0; tick();
`endif

    // Random jobs checked against the job-level scoreboard.
    for (int j = 0; j < 30; j++) begin
      bit running, done_sent;
      int cd;
      s = $urandom; d = $urandom;
      repeat ($urandom_range(0, 3)) tick();
      crf_ac_UPSRCAR = s; crf_ac_UPDSTAR = d; crf_ac_UPSTR = 32'd1;
      w0 = wq_addr.size(); hs0 = hs_n;
      running = 1'b0; done_sent = 1'b0; cd = 0; k = 0;
      while (!crf_ac_UPENDR[0] && k < 400) begin
        int hb;
        job_ready = (running || done_sent) ? 1'b0 : 1'($urandom_range(0, 1));
        crf_ac_wbusy = ($urandom_range(0, 3) == 0);
        eng_done = 1'b0;
        if (running && cd == 0) begin eng_done = 1'b1; running = 1'b0; done_sent = 1'b1; end
        else if (running) cd--;
        else eng_done = ($urandom_range(0, 7) == 0);
        if (ac_busy) begin crf_ac_UPSRCAR = $urandom; crf_ac_UPDSTAR = $urandom; end
        hb = hs_n;
        tick(); k++;
        if (hs_n != hb) begin running = 1'b1; cd = $urandom_range(0, 20); end
      end
      eng_done = 1'b0; crf_ac_wbusy = 1'b0; job_ready = 1'b0;
      exp_cnt++;
      check("rnd_done_in_time", {63'd0, crf_ac_UPENDR[0]}, 64'd1);
      check("rnd_one_hs", 64'(hs_n - hs0), 64'd1);
      check("rnd_hs_addr", {hs_src, hs_dst}, {s, d});
      check("rnd_write_count", 64'(wq_addr.size() - w0), 64'd2);
      if (wq_addr.size() >= w0 + 2)
        check("rnd_write_order", {wq_addr[w0], wq_data[w0], wq_addr[w0+1], wq_data[w0+1]},
              {32'd0, 32'd0, 32'd1, 32'd1});
      tick();
      check("rnd_cnt", {48'd0, job_cnt}, {48'd0, exp_cnt});
      check("rnd_idle", {62'd0, ac_busy, ac_crf_wrt}, 64'd0);
      if ($urandom_range(0, 1) == 1) begin
        crf_ac_UPSTR = 32'd1;
        seen = 1'b0;
        repeat (3) begin tick(); if (job_valid) seen = 1'b1; end
        check("rnd_no_relaunch", {63'd0, seen}, 64'd0);
      end
      crf_ac_UPSTR = 32'd0; crf_ac_UPENDR = 32'd0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
